// File: rtl/nand_cmd_fsm_if.sv
// NAND pin bundle between the command sequencer and the flash device.
//   io_i    : IO bus as driven by the device
//   io_o    : IO bus as driven by the controller, qualified by io_oe
//   io_oe   : controller IO output enable
//   ce_n_o, cle_o, ale_o, we_n_o, re_n_o : controller-driven control pins
//   rb_n_i  : device ready/busy_n (already synchronised)
// master: controller side, slave: device/model side.
interface nand_cmd_fsm_if;
  logic [7:0] io_i;
  logic [7:0] io_o;
  logic       io_oe;
  logic       ce_n_o;
  logic       cle_o;
  logic       ale_o;
  logic       we_n_o;
  logic       re_n_o;
  logic       rb_n_i;

  modport master (
    input  io_i, rb_n_i,
    output io_o, io_oe, ce_n_o, cle_o, ale_o, we_n_o, re_n_o
  );

  modport slave (
    output io_i, rb_n_i,
    input  io_o, io_oe, ce_n_o, cle_o, ale_o, we_n_o, re_n_o
  );
endinterface

// File: rtl/nand_cmd_fsm.sv
// NAND command sequencer: RESET (0xFF), READ ID (0x90) and READ STATUS (0x70).
// A rising edge of start_i in IDLE latches opcode and WE_n/RE_n phase lengths,
// then the FSM drives the NAND pins and returns read bytes on the
// fwe/faddr/fdata register-file write port.
// Ports:
//   aclk, rstn           clock, asynchronous active-low reset
//   start_i              level start request (rising edge starts a command)
//   command_i[15:0]      [7:0] opcode, [15:8] unused
//   settime_i/holdtime_i low/high phase length in aclk cycles (0 acts as 1)
//   pins                 NAND pin bundle (master side)
//   fwe_o/faddr_o/fdata_o one-cycle write strobe, address, data
//   state_o[11:0]        one-hot state word
//   done_o, err_o        completion and error levels, cleared on next start
module nand_cmd_fsm #(
  parameter logic [19:0] RB_TIMEOUT = 20'hFFFFF,
  parameter int unsigned TWHR_CYC   = 8,
  parameter int unsigned ID_BYTES   = 6
) (
  input  logic                  aclk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [15:0]           command_i,
  input  logic [15:0]           settime_i,
  input  logic [15:0]           holdtime_i,
  nand_cmd_fsm_if.master        pins,
  output logic                  fwe_o,
  output logic [11:0]           faddr_o,
  output logic [7:0]            fdata_o,
  output logic [11:0]           state_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [7:0]  OP_RESET   = 8'hFF;
  localparam logic [7:0]  OP_READID  = 8'h90;
  localparam logic [7:0]  OP_STATUS  = 8'h70;
  localparam logic [11:0] ID_BASE    = 12'h500;
  localparam logic [11:0] STAT_ADDR  = 12'h506;
  localparam logic [15:0] TWHR_M1    = 16'(TWHR_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CMD_LO  = 4'd1,
    S_CMD_HI  = 4'd2,
    S_ADR_LO  = 4'd3,
    S_ADR_HI  = 4'd4,
    S_TWHR    = 4'd5,
    S_RD_LO   = 4'd6,
    S_RD_HI   = 4'd7,
    S_WAIT_RB = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  state_t      state, state_nxt;
  logic        start_q;
  logic [7:0]  op_q;
  logic [15:0] tlo_q, thi_q;      // phase lengths minus one
  logic [15:0] cnt, cnt_nxt;
  logic [19:0] rb_cnt, rb_cnt_nxt;
  logic [2:0]  byte_q;
  logic        done_q, err_q;

  logic        start_rise;
  logic        start_take;
  logic        op_ok_in;
  logic        last_phase;
  logic        more_bytes;
  logic        timeout;
  logic        err_set;
  logic [15:0] tlo_in, thi_in;
  logic        cmd_hi_unused;

  assign cmd_hi_unused = ^command_i[15:8];

  assign start_rise = start_i & ~start_q;
  assign start_take = start_rise && (state == S_IDLE);
  assign op_ok_in   = (command_i[7:0] == OP_RESET) || (command_i[7:0] == OP_READID) ||
                      (command_i[7:0] == OP_STATUS);
  assign tlo_in     = (settime_i  == '0) ? '0 : settime_i  - 16'd1;
  assign thi_in     = (holdtime_i == '0) ? '0 : holdtime_i - 16'd1;
  assign last_phase = (cnt == '0);
  // byte_q already counts the byte strobed in the preceding RD_LO
  assign more_bytes = (op_q == OP_READID) && (32'(byte_q) < ID_BYTES);
  assign err_set    = timeout | (start_take & ~op_ok_in);

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      op_q    <= '0;
      tlo_q   <= '0;
      thi_q   <= '0;
      cnt     <= '0;
      rb_cnt  <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start_i;
      cnt     <= cnt_nxt;
      rb_cnt  <= rb_cnt_nxt;
      if (start_take) begin
        op_q   <= command_i[7:0];
        tlo_q  <= tlo_in;
        thi_q  <= thi_in;
        byte_q <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (fwe_o)
        byte_q <= byte_q + 3'd1;
      // set after the clear so an unsupported opcode finishes in one pass
      if (state_nxt == S_DONE)
        done_q <= 1'b1;
      if (err_set)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = last_phase ? cnt : cnt - 16'd1;
    rb_cnt_nxt = rb_cnt;
    timeout    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_take) begin
          if (op_ok_in) begin
            state_nxt = S_CMD_LO;
            cnt_nxt   = tlo_in;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_CMD_LO: if (last_phase) begin
        state_nxt = S_CMD_HI;
        cnt_nxt   = thi_q;
      end
      S_CMD_HI: if (last_phase) begin
        if (op_q == OP_RESET) begin
          state_nxt  = S_WAIT_RB;
          rb_cnt_nxt = '0;
        end else if (op_q == OP_READID) begin
          state_nxt = S_ADR_LO;
          cnt_nxt   = tlo_q;
        end else begin
          state_nxt = S_TWHR;
          cnt_nxt   = TWHR_M1;
        end
      end
      S_ADR_LO: if (last_phase) begin
        state_nxt = S_ADR_HI;
        cnt_nxt   = thi_q;
      end
      S_ADR_HI: if (last_phase) begin
        state_nxt = S_TWHR;
        cnt_nxt   = TWHR_M1;
      end
      S_TWHR: if (last_phase) begin
        state_nxt = S_RD_LO;
        cnt_nxt   = tlo_q;
      end
      S_RD_LO: if (last_phase) begin
        state_nxt = S_RD_HI;
        cnt_nxt   = thi_q;
      end
      S_RD_HI: if (last_phase) begin
        if (more_bytes) begin
          state_nxt = S_RD_LO;
          cnt_nxt   = tlo_q;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_WAIT_RB: begin
        // first two cycles cover tWB, before R/B_n is meaningful
        if (rb_cnt < 20'd2) begin
          rb_cnt_nxt = rb_cnt + 20'd1;
        end else if (pins.rb_n_i) begin
          state_nxt = S_DONE;
        end else if (rb_cnt >= RB_TIMEOUT) begin
          state_nxt = S_DONE;
          timeout   = 1'b1;
        end else begin
          rb_cnt_nxt = rb_cnt + 20'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pins.ce_n_o = 1'b0;
    pins.cle_o  = 1'b0;
    pins.ale_o  = 1'b0;
    pins.we_n_o = 1'b1;
    pins.re_n_o = 1'b1;
    pins.io_oe  = 1'b0;
    pins.io_o   = '0;
    fwe_o       = 1'b0;
    faddr_o     = '0;
    fdata_o     = '0;
    state_o     = '0;
    state_o[state] = 1'b1;
    unique case (state)
      S_CMD_LO, S_CMD_HI: begin
        pins.cle_o  = 1'b1;
        pins.io_oe  = 1'b1;
        pins.io_o   = op_q;
        pins.we_n_o = (state != S_CMD_LO);
      end
      S_ADR_LO, S_ADR_HI: begin
        pins.ale_o  = 1'b1;
        pins.io_oe  = 1'b1;
        pins.we_n_o = (state != S_ADR_LO);
      end
      S_RD_LO: begin
        pins.re_n_o = 1'b0;
        if (last_phase) begin
          fwe_o   = 1'b1;
          faddr_o = (op_q == OP_STATUS) ? STAT_ADDR : ID_BASE + 12'(byte_q);
          fdata_o = pins.io_i;
        end
      end
      S_TWHR, S_RD_HI, S_WAIT_RB: ;
      default: pins.ce_n_o = 1'b1;   // IDLE, DONE
    endcase
  end

  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_nand_cmd_fsm.sv
module tb_nand_cmd_fsm;
  logic        aclk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] command_i = '0;
  logic [15:0] settime_i = '0;
  logic [15:0] holdtime_i = '0;
  logic        fwe_o;
  logic [11:0] faddr_o;
  logic [7:0]  fdata_o;
  logic [11:0] state_o;
  logic        done_o;
  logic        err_o;

  nand_cmd_fsm_if nif();

  nand_cmd_fsm #(.RB_TIMEOUT(20'd100), .TWHR_CYC(8), .ID_BYTES(6)) dut (
    .aclk       (aclk),
    .rstn       (rstn),
    .start_i    (start_i),
    .command_i  (command_i),
    .settime_i  (settime_i),
    .holdtime_i (holdtime_i),
    .pins       (nif.master),
    .fwe_o      (fwe_o),
    .faddr_o    (faddr_o),
    .fdata_o    (fdata_o),
    .state_o    (state_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // NAND device model: ID bytes advance on every RE_n rise
  logic [7:0] id_tab [6] = '{8'h2C, 8'hDA, 8'h90, 8'h95, 8'h06, 8'h00};
  logic       status_mode = 1'b0;
  int         re_rises = 0;
  int         rd_base = 0;

  always @(posedge nif.re_n_o) re_rises++;

  always_comb begin
    int idx;
    idx = re_rises - rd_base;
    if (status_mode)               nif.io_i = 8'hE0;
    else if (idx >= 0 && idx < 6)  nif.io_i = id_tab[idx];
    else                           nif.io_i = 8'hFF;
  end

  // Pin monitor, sampled on the falling edge
  logic [19:0] fwe_q [$];
  logic [9:0]  wr_q [$];
  int welo_q [$], cle_q [$], relo_q [$], rehi_q [$], gap_q [$];
  int ce_cnt = 0;
  int we_lo = 0, cle_len = 0, re_lo = 0, re_hi = 0, since_we = 0;
  logic prev_re = 1'b1;

  always @(negedge aclk) begin
    if (!rstn) begin
      we_lo = 0; cle_len = 0; re_lo = 0; re_hi = 0; prev_re = 1'b1;
    end else begin
      if (!nif.re_n_o) begin
        if (prev_re) begin
          gap_q.push_back(since_we);
          if (re_hi > 0) rehi_q.push_back(re_hi);
          re_hi = 0;
        end
        re_lo++;
      end else begin
        if (re_lo > 0) begin relo_q.push_back(re_lo); re_lo = 0; re_hi = 1; end
        else if (re_hi > 0) re_hi++;
      end
      if (nif.ce_n_o) re_hi = 0;
      prev_re = nif.re_n_o;
      if (!nif.we_n_o) we_lo++;
      else if (we_lo > 0) begin
        welo_q.push_back(we_lo);
        wr_q.push_back({nif.cle_o, nif.ale_o, nif.io_o});
        we_lo = 0;
        since_we = 1;
      end else since_we++;
      if (nif.cle_o) cle_len++;
      else if (cle_len > 0) begin cle_q.push_back(cle_len); cle_len = 0; end
      if (fwe_o) fwe_q.push_back({faddr_o, fdata_o});
      if (!nif.ce_n_o) ce_cnt++;
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge aclk);
  endtask

  task automatic start_cmd(input logic [15:0] cmd, input logic [15:0] s,
                           input logic [15:0] h, input bit keep);
    @(negedge aclk);
    rd_base    = re_rises;
    command_i  = cmd;
    settime_i  = s;
    holdtime_i = h;
    start_i    = 1'b1;
    @(negedge aclk);
    if (!keep) start_i = 1'b0;
    command_i  = 16'hAB12;   // later input changes must not matter
    settime_i  = 16'd7;
    holdtime_i = 16'd7;
  endtask

  task automatic wait_done(input string tag, input int maxc, output int n);
    n = 0;
    while (!done_o && n < maxc) begin
      @(negedge aclk);
      n++;
    end
    check({tag, "_done"}, 32'(done_o), 1);
  endtask

  task automatic check_pins_idle(input string tag);
    check({tag, "_ce_n"},  32'(nif.ce_n_o), 1);
    check({tag, "_we_n"},  32'(nif.we_n_o), 1);
    check({tag, "_re_n"},  32'(nif.re_n_o), 1);
    check({tag, "_cle"},   32'(nif.cle_o), 0);
    check({tag, "_ale"},   32'(nif.ale_o), 0);
    check({tag, "_io_oe"}, 32'(nif.io_oe), 0);
    check({tag, "_io_o"},  32'(nif.io_o), 0);
    check({tag, "_fwe"},   32'(fwe_o), 0);
    check({tag, "_state"}, 32'(state_o), 32'h001);
  endtask

  initial begin
    int n, f0, w0, l0, c0, r0, h0, ce0, bad;
    nif.rb_n_i = 1'b1;

    // Reset state
    cycles(3);
    check_pins_idle("rst");
    check("rst_faddr", 32'(faddr_o), 0);
    check("rst_fdata", 32'(fdata_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);
    @(negedge aclk);
    rstn = 1'b1;
    cycles(2);

    // 1: RESET, set=2 hold=1, busy for 50 cycles
    w0 = wr_q.size(); l0 = welo_q.size(); c0 = cle_q.size();
    nif.rb_n_i = 1'b0;
    start_cmd(16'h00FF, 16'd2, 16'd1, 1'b0);
    cycles(50);
    check("t1_busy_done", 32'(done_o), 0);
    check("t1_busy_state", 32'(state_o), 32'h100);
    nif.rb_n_i = 1'b1;
    wait_done("t1", 10, n);
    check("t1_lat", 32'(n), 1);
    check("t1_err", 32'(err_o), 0);
    check("t1_state_done", 32'(state_o), 32'h200);
    check("t1_nwr", 32'(wr_q.size() - w0), 1);
    if (wr_q.size() > w0) check("t1_wr", 32'(wr_q[w0]), {22'd0, 2'b10, 8'hFF});
    if (welo_q.size() > l0) check("t1_welo", 32'(welo_q[l0]), 2);
    if (cle_q.size() > c0) check("t1_cle_len", 32'(cle_q[c0]), 3);
    @(negedge aclk);
    check("t1_idle", 32'(state_o), 32'h001);
    check("t1_done_hold", 32'(done_o), 1);

    // 2: READ ID, set=hold=1
    f0 = fwe_q.size(); w0 = wr_q.size();
    start_cmd(16'hFF90, 16'd1, 16'd1, 1'b0);
    check("t2_done_clr", 32'(done_o), 0);
    wait_done("t2", 300, n);
    check("t2_err", 32'(err_o), 0);
    check("t2_nfwe", 32'(fwe_q.size() - f0), 6);
    for (int i = 0; i < 6; i++)
      if (fwe_q.size() > f0 + i)
        check($sformatf("t2_fwe%0d", i), 32'(fwe_q[f0 + i]), {12'd0, 12'h500 + 12'(i), id_tab[i]});
    check("t2_nwr", 32'(wr_q.size() - w0), 2);
    if (wr_q.size() > w0 + 1) begin
      check("t2_wr_cmd", 32'(wr_q[w0]), {22'd0, 2'b10, 8'h90});
      check("t2_wr_adr", 32'(wr_q[w0 + 1]), {22'd0, 2'b01, 8'h00});
    end

    // 3: READ STATUS
    status_mode = 1'b1;
    f0 = fwe_q.size(); r0 = gap_q.size();
    start_cmd(16'h0070, 16'd1, 16'd1, 1'b0);
    wait_done("t3", 200, n);
    status_mode = 1'b0;
    check("t3_nfwe", 32'(fwe_q.size() - f0), 1);
    if (fwe_q.size() > f0) check("t3_fwe", 32'(fwe_q[f0]), {12'd0, 12'h506, 8'hE0});
    if (gap_q.size() > r0) begin
      check("t3_twhr_min", 32'(gap_q[r0] >= 8), 1);
      check("t3_twhr", 32'(gap_q[r0]), 9);
    end

    // 4: zero phase lengths, then unsupported opcode
    f0 = fwe_q.size(); l0 = welo_q.size(); c0 = cle_q.size();
    r0 = relo_q.size(); h0 = rehi_q.size();
    start_cmd(16'h0090, 16'd0, 16'd0, 1'b0);
    wait_done("t4", 300, n);
    check("t4_nfwe", 32'(fwe_q.size() - f0), 6);
    check("t4_nwelo", 32'(welo_q.size() - l0), 2);
    check("t4_nrelo", 32'(relo_q.size() - r0), 6);
    check("t4_nrehi", 32'(rehi_q.size() - h0), 5);
    bad = 0;
    for (int i = l0; i < welo_q.size(); i++) if (welo_q[i] != 1) bad++;
    for (int i = r0; i < relo_q.size(); i++) if (relo_q[i] != 1) bad++;
    for (int i = h0; i < rehi_q.size(); i++) if (rehi_q[i] != 1) bad++;
    check("t4_phase1_bad", 32'(bad), 0);
    if (cle_q.size() > c0) check("t4_cle_len", 32'(cle_q[c0]), 2);
    ce0 = ce_cnt; w0 = wr_q.size();
    start_cmd(16'h0012, 16'd1, 16'd1, 1'b0);
    wait_done("t4bad", 10, n);
    check("t4bad_err", 32'(err_o), 1);
    check("t4bad_ce", 32'(ce_cnt - ce0), 0);
    check("t4bad_wr", 32'(wr_q.size() - w0), 0);

    // 5: R/B timeout with start held high, then restart
    nif.rb_n_i = 1'b0;
    start_cmd(16'h00FF, 16'd1, 16'd1, 1'b1);
    check("t5_err_clr", 32'(err_o), 0);
    wait_done("t5", 300, n);
    check("t5_window", 32'(n >= 95 && n <= 110), 1);
    check("t5_err", 32'(err_o), 1);
    cycles(20);
    check("t5_norestart_state", 32'(state_o), 32'h001);
    check("t5_norestart_done", 32'(done_o), 1);
    check("t5_norestart_err", 32'(err_o), 1);
    start_i = 1'b0;
    cycles(2);
    nif.rb_n_i = 1'b1;
    start_cmd(16'h00FF, 16'd1, 16'd1, 1'b0);
    check("t5_re_done_clr", 32'(done_o), 0);
    check("t5_re_err_clr", 32'(err_o), 0);
    wait_done("t5re", 50, n);
    check("t5re_err", 32'(err_o), 0);

    // 6: reset during RD_LO of READ ID
    f0 = fwe_q.size();
    start_cmd(16'h0090, 16'd4, 16'd1, 1'b0);
    n = 0;
    while (nif.re_n_o && n < 200) begin @(negedge aclk); n++; end
    check("t6_reached_rd", 32'(nif.re_n_o), 0);
    #1 rstn = 1'b0;
    #1 check_pins_idle("t6");
    check("t6_done", 32'(done_o), 0);
    cycles(5);
    rstn = 1'b1;
    cycles(5);
    check("t6_nfwe", 32'(fwe_q.size() - f0), 0);
    check("t6_state_after", 32'(state_o), 32'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
